ack_edge_gen: RTL and testbench

- Bus-slave acknowledge generator.
- Delays a slave-select strobe by a programmable number of clocks, separately for reads and writes, to produce the bus ack.
- Also exports rising, falling and any-edge pulses of the strobe; slaves use these to load burst address counters.
- Instantiated inside memory and peripheral slaves, between the bus decode (cs & cyc & stb) and ack_o.

---
 rtl/ack_gen_pkg.sv | 24 ++
 rtl/edge_detect.sv | 35 +++
 rtl/ack_edge_gen.sv | 133 +++++++++++++
 tb/tb_ack_edge_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ack_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ack_gen_pkg
// Purpose  : Shared constants and ack-mode encoding for the ack_edge_gen slice.
// Revision : 1.0
// ============================================================================
package ack_gen_pkg;

  localparam int MAX_STAGES = 7;

  typedef enum logic [0:0] {
    HOLD  = 1'b0,
    PULSE = 1'b1
  } ack_mode_e;

  // Out-of-range stage counts saturate instead of building oversized chains.
  function automatic int clamp_stages(input int n);
    if (n < 0) return 0;
    if (n > MAX_STAGES) return MAX_STAGES;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Purpose  : Rising / falling / any-edge pulses of a strobe against a one-flop
//            history that only advances on enabled clocks.
// Revision : 1.0
// ============================================================================
module edge_detect
  import ack_gen_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic i,
  output logic pe_o,
  output logic ne_o,
  output logic ee_o
);

  logic r_i_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_i_d <= 1'b0;
    end else if (ce_i) begin
      r_i_d <= i;
    end
  end

  assign pe_o = i & ~r_i_d;
  assign ne_o = ~i & r_i_d;
  assign ee_o = i ^ r_i_d;

endmodule
`default_nettype wire

// File: rtl/ack_edge_gen.sv
`default_nettype none
// ============================================================================
// Module   : ack_edge_gen
// Purpose  : Bus-slave ack generator: delays the select strobe by separate
//            read/write stage counts and exports strobe edge pulses.
//            Define ACK_GEN_PULSE_EN for one ack pulse per select assertion.
// Revision : 1.0
// ============================================================================
module ack_edge_gen
  import ack_gen_pkg::*;
#(
  parameter int READ_STAGES     = 1,
  parameter int WRITE_STAGES    = 1,
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic i,
  input  logic we_i,
  output logic o,
  output logic pe_o,
  output logic ne_o,
  output logic ee_o
);

  localparam int c_RD_N = clamp_stages(READ_STAGES);
  localparam int c_WR_N = clamp_stages(WRITE_STAGES);

`ifdef ACK_GEN_PULSE_EN
  localparam ack_mode_e c_MODE = PULSE;
`else
  localparam ack_mode_e c_MODE = HOLD;
`endif

  logic w_wr_sel;
  logic w_rd_term;
  logic w_wr_term;
  logic w_ack_c;
  logic w_ack_hold;

  assign w_wr_sel = i & we_i;

  // Each stage ANDs in the live select so any gap flushes the whole chain.
  if (c_RD_N > 0) begin : g_rd_chain
    logic [c_RD_N-1:0] r_rd;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_rd <= '0;
      end else if (ce_i) begin
        r_rd[0] <= i;
        for (int k = 1; k < c_RD_N; k++) begin
          r_rd[k] <= r_rd[k-1] & i;
        end
      end
    end

    assign w_rd_term = r_rd[c_RD_N-1];
  end else begin : g_rd_bypass
    assign w_rd_term = i;
  end

  if (c_WR_N > 0) begin : g_wr_chain
    logic [c_WR_N-1:0] r_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_wr <= '0;
      end else if (ce_i) begin
        r_wr[0] <= w_wr_sel;
        for (int k = 1; k < c_WR_N; k++) begin
          r_wr[k] <= r_wr[k-1] & w_wr_sel;
        end
      end
    end

    assign w_wr_term = r_wr[c_WR_N-1];
  end else begin : g_wr_bypass
    assign w_wr_term = w_wr_sel;
  end

  assign w_ack_c = i & (we_i ? w_wr_term : w_rd_term);

  if (REGISTER_OUTPUT) begin : g_reg_out
    logic r_ack;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_ack <= 1'b0;
      end else if (ce_i) begin
        r_ack <= w_ack_c;
      end
    end

    assign w_ack_hold = r_ack;
  end else begin : g_comb_out
    assign w_ack_hold = w_ack_c;
  end

  // Pulse mode masks the held ack once it has been seen on an enabled edge.
  if (c_MODE == PULSE) begin : g_pulse
    logic r_acked;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_acked <= 1'b0;
      end else if (ce_i) begin
        if (!i) begin
          r_acked <= 1'b0;
        end else if (w_ack_hold) begin
          r_acked <= 1'b1;
        end
      end
    end

    assign o = w_ack_hold & ~r_acked;
  end else begin : g_hold
    assign o = w_ack_hold;
  end

  edge_detect u_edge_detect (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ce_i  (ce_i),
    .i     (i),
    .pe_o  (pe_o),
    .ne_o  (ne_o),
    .ee_o  (ee_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_ack_edge_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ack_edge_gen
// Purpose  : Drives several ack_edge_gen configurations from one stimulus
//            stream and compares them against a run-length reference model.
// Revision : 1.0
// ============================================================================
module tb_ack_edge_gen;

  localparam int N_DUT = 5;
  localparam int CNT_SAT = 8;

  function automatic int rs_of(input int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 3;
      3: return 2;
      default: return 7;
    endcase
  endfunction

  function automatic int ws_of(input int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 2;
      3: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic bit reg_of(input int g);
    case (g)
      0: return 1'b1;
      1: return 1'b0;
      2: return 1'b0;
      3: return 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic i;
  logic we;
  logic [N_DUT-1:0] o_w;
  logic [N_DUT-1:0] pe_w;
  logic [N_DUT-1:0] ne_w;
  logic [N_DUT-1:0] ee_w;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    ack_edge_gen #(
      .READ_STAGES     (rs_of(g)),
      .WRITE_STAGES    (ws_of(g)),
      .REGISTER_OUTPUT (reg_of(g))
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .ce_i  (ce),
      .i     (i),
      .we_i  (we),
      .o     (o_w[g]),
      .pe_o  (pe_w[g]),
      .ne_o  (ne_w[g]),
      .ee_o  (ee_w[g])
    );
  end

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state: consecutive enabled edges with select (and write) high.
  int   rcnt  [N_DUT];
  int   wcnt  [N_DUT];
  logic ack_q [N_DUT];
  logic acked [N_DUT];
  logic hist;

  task automatic check_bit(input string tag, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, act, exp);
    end
  endtask

  function automatic logic exp_ackc(input int g);
    logic rt;
    logic wt;
    rt = (rs_of(g) == 0) ? 1'b1 : (rcnt[g] >= rs_of(g));
    wt = (ws_of(g) == 0) ? 1'b1 : (wcnt[g] >= ws_of(g));
    return i & (we ? wt : rt);
  endfunction

  function automatic logic exp_o(input int g);
    logic hold;
    hold = reg_of(g) ? ack_q[g] : exp_ackc(g);
`ifdef ACK_GEN_PULSE_EN
    return hold & ~acked[g];
`else
    return hold;
`endif
  endfunction

  task automatic model_reset();
    for (int g = 0; g < N_DUT; g++) begin
      rcnt[g]  = 0;
      wcnt[g]  = 0;
      ack_q[g] = 1'b0;
      acked[g] = 1'b0;
    end
    hist = 1'b0;
  endtask

  task automatic model_update();
    logic o_now;
    logic ackc;
    for (int g = 0; g < N_DUT; g++) begin
      o_now = exp_o(g);
      ackc  = exp_ackc(g);
      ack_q[g] = ackc;
      if (!i)        acked[g] = 1'b0;
      else if (o_now) acked[g] = 1'b1;
      rcnt[g] = i ? ((rcnt[g] < CNT_SAT) ? rcnt[g] + 1 : CNT_SAT) : 0;
      wcnt[g] = (i & we) ? ((wcnt[g] < CNT_SAT) ? wcnt[g] + 1 : CNT_SAT) : 0;
    end
    hist = i;
  endtask

  task automatic check_all();
    for (int g = 0; g < N_DUT; g++) begin
      check_bit($sformatf("o[%0d]", g),  o_w[g],  exp_o(g));
      check_bit($sformatf("pe[%0d]", g), pe_w[g], i & ~hist);
      check_bit($sformatf("ne[%0d]", g), ne_w[g], ~i & hist);
      check_bit($sformatf("ee[%0d]", g), ee_w[g], i ^ hist);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic ni, input logic nwe, input logic nce);
    i  = ni;
    we = nwe;
    ce = nce;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst && ce) model_update();
    cyc++;
    #1;
  endtask

  task automatic async_reset(input logic ni);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_bit("rst_o0", o_w[0], 1'b0);
    check_all();
    i  = ni;
    ce = 1'b1;
    @(negedge clk);
    check_all();
    check_bit("rst_pe0", pe_w[0], ni);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  task automatic repeat_step(input int n, input logic ni, input logic nwe, input logic nce);
    for (int k = 0; k < n; k++) step(ni, nwe, nce);
  endtask

  logic ri;
  logic rwe;
  logic rce;

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    i   = 1'b0;
    we  = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat_step(3, 1'b0, 1'b0, 1'b1);
    // read latency, then drop
    repeat_step(5, 1'b1, 1'b0, 1'b1);
    repeat_step(3, 1'b0, 1'b0, 1'b1);
    // write latency
    repeat_step(9, 1'b1, 1'b1, 1'b1);
    repeat_step(3, 1'b0, 1'b0, 1'b1);
    // restart after a one-cycle gap
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat_step(6, 1'b1, 1'b0, 1'b1);
    repeat_step(2, 1'b0, 1'b0, 1'b1);
    // stall mid-delay
    step(1'b1, 1'b0, 1'b1);
    repeat_step(2, 1'b1, 1'b0, 1'b0);
    repeat_step(5, 1'b1, 1'b0, 1'b1);
    repeat_step(2, 1'b0, 1'b0, 1'b1);
    // write qualifier switching mid-select
    repeat_step(4, 1'b1, 1'b0, 1'b1);
    repeat_step(9, 1'b1, 1'b1, 1'b1);
    repeat_step(2, 1'b1, 1'b0, 1'b1);
    repeat_step(2, 1'b0, 1'b0, 1'b1);
    // async reset while acking, select held through release
    repeat_step(4, 1'b1, 1'b0, 1'b1);
    async_reset(1'b1);
    repeat_step(9, 1'b1, 1'b0, 1'b1);
    repeat_step(2, 1'b0, 1'b0, 1'b1);

    ri  = 1'b0;
    rwe = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) ri = ~ri;
      if ($urandom_range(7) == 0) rwe = ~rwe;
      rce = ($urandom_range(7) != 0);
      if ($urandom_range(499) == 0) async_reset(ri);
      step(ri, rwe, rce);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
